cs_len_decode: RTL and testbench

CS_LEN_DECODE -- requirements
Module: cs_len_decode

---
 rtl/cs_len_decode.sv | 133 +++++++++++++
 tb/tb_cs_len_decode.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cs_len_decode.sv
// cs_len_decode
//   Decodes the active device count from a received Ethernet frame length
//   and cross-checks it against the received ADC burst length.
//   eth_tx_len = HEAD + n*TX_UNIT and adc_rx_len = n*RX_UNIT are expected.
//   n is found by repeated subtraction, one TX_UNIT per cycle.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   eth_tx_len  in   [11:0] Ethernet frame length (sampled on acceptance)
//   adc_rx_len  in   [9:0]  ADC burst length (sampled on acceptance)
//   fs          in   request level (four-phase handshake with fd)
//   fd          out  done level, high only in DONE
//   dev_num     out  [3:0] decoded device count
//   kdev        out  [7:0] device mask, low dev_num bits set; 0 on error
//   err         out  decode inconsistency flag for the last transaction
//
// state | meaning
// IDLE  | waiting for fs; inputs latched on acceptance
// LOAD  | strip header, detect underflow, clear counters
// DIV   | one TX_UNIT subtraction per cycle
// CHECK | evaluate consistency, register results
// DONE  | fd high until fs drops
module cs_len_decode #(
  parameter int unsigned HEAD    = 12,
  parameter int unsigned TX_UNIT = 384,
  parameter int unsigned RX_UNIT = 64,
  parameter int unsigned MAX_DEV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] eth_tx_len,
  input  logic [9:0]  adc_rx_len,
  input  logic        fs,
  output logic        fd,
  output logic [3:0]  dev_num,
  output logic [7:0]  kdev,
  output logic        err
);

  localparam logic [11:0] HEAD_L = 12'(HEAD);
  localparam logic [11:0] TX_L   = 12'(TX_UNIT);
  localparam logic [10:0] RX_L   = 11'(RX_UNIT);
  localparam logic [3:0]  MAX_L  = 4'(MAX_DEV);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DIV   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [11:0] eth_q;
  logic [9:0]  adc_q;
  logic [11:0] rem;
  logic [3:0]  cnt;
  logic [10:0] acc;
  logic        underflow;
  logic        step;
  logic        err_next;
  logic [8:0]  mask_full;

  // cnt <= MAX_DEV lets one extra step happen, so cnt saturates at MAX_DEV+1
  // and a frame with too many units is flagged instead of silently truncated.
  assign step = (rem >= TX_L) && (cnt <= MAX_L);

  assign err_next = underflow || (rem != 12'd0) || (cnt > MAX_L) ||
                    (acc != {1'b0, adc_q});

  assign mask_full = (9'd1 << cnt) - 9'd1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fs) state_next = LOAD;
      LOAD:    state_next = DIV;
      DIV:     if (!step) state_next = CHECK;
      CHECK:   state_next = DONE;
      DONE:    if (!fs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fd        <= 1'b0;
      eth_q     <= '0;
      adc_q     <= '0;
      rem       <= '0;
      cnt       <= '0;
      acc       <= '0;
      underflow <= 1'b0;
      dev_num   <= '0;
      kdev      <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      // Registered from next state so fd never decodes a transient.
      fd    <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (fs) begin
            eth_q <= eth_tx_len;
            adc_q <= adc_rx_len;
          end
        end
        LOAD: begin
          underflow <= (eth_q < HEAD_L);
          rem       <= (eth_q < HEAD_L) ? 12'd0 : (eth_q - HEAD_L);
          cnt       <= '0;
          acc       <= '0;
        end
        DIV: begin
          if (step) begin
            rem <= rem - TX_L;
            cnt <= cnt + 4'd1;
            acc <= acc + RX_L;
          end
        end
        CHECK: begin
          dev_num <= cnt;
          err     <= err_next;
          kdev    <= err_next ? 8'h00 : mask_full[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_len_decode.sv
module tb_cs_len_decode;

  logic        clk;
  logic        rst_n;
  logic [11:0] eth_tx_len;
  logic [9:0]  adc_rx_len;
  logic        fs;
  logic        fd;
  logic [3:0]  dev_num;
  logic [7:0]  kdev;
  logic        err;

  int vecs = 0;
  int miss = 0;

  cs_len_decode dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .eth_tx_len (eth_tx_len),
    .adc_rx_len (adc_rx_len),
    .fs         (fs),
    .fd         (fd),
    .dev_num    (dev_num),
    .kdev       (kdev),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    fs = 1'b0;
    eth_tx_len = '0;
    adc_rx_len = '0;
    #12;
    vecs++;
    if ({fd, dev_num, kdev, err} !== 14'd0) begin
      miss++;
      $display("FAIL reset_outputs got fd=%b dev=%0d kdev=%h err=%b want all 0", fd, dev_num, kdev, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (fd !== 1'b0) begin
      miss++;
      $display("FAIL idle_fd got %b want 0", fd);
    end
  endtask

  // Runs one transaction. Inputs are scrambled right after the acceptance
  // edge; pulse=1 drops fs immediately, pulse=0 holds fs through DONE.
  task automatic run_txn(input string name, input logic [11:0] eth, input logic [9:0] adc,
                         input bit pulse, input int exp_lat, input logic [3:0] exp_dev,
                         input logic [7:0] exp_kdev, input logic exp_err);
    int lat;
    lat = -1;
    @(negedge clk);
    eth_tx_len = eth;
    adc_rx_len = adc;
    fs = 1'b1;
    @(posedge clk);
    #1;
    eth_tx_len = ~eth;
    adc_rx_len = ~adc;
    if (pulse) fs = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (fd === 1'b1) begin
        lat = k;
        break;
      end
    end
    vecs++;
    if (lat != exp_lat) begin
      miss++;
      $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    if (lat < 0) begin
      fs = 1'b0;
      repeat (40) @(posedge clk);
      return;
    end
    vecs++;
    if (dev_num !== exp_dev) begin
      miss++;
      $display("FAIL %s dev_num got %0d want %0d", name, dev_num, exp_dev);
    end
    vecs++;
    if (kdev !== exp_kdev) begin
      miss++;
      $display("FAIL %s kdev got %h want %h", name, kdev, exp_kdev);
    end
    vecs++;
    if (err !== exp_err) begin
      miss++;
      $display("FAIL %s err got %b want %b", name, err, exp_err);
    end
    if (!pulse) begin
      repeat (3) @(posedge clk);
      #1;
      vecs++;
      if (fd !== 1'b1) begin
        miss++;
        $display("FAIL %s fd_hold got %b want 1", name, fd);
      end
      fs = 1'b0;
    end
    @(posedge clk);
    #1;
    vecs++;
    if (fd !== 1'b0) begin
      miss++;
      $display("FAIL %s fd_drop got %b want 0", name, fd);
    end
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({dev_num, kdev, err} !== {exp_dev, exp_kdev, exp_err}) begin
      miss++;
      $display("FAIL %s idle_hold got dev=%0d kdev=%h err=%b want dev=%0d kdev=%h err=%b",
               name, dev_num, kdev, err, exp_dev, exp_kdev, exp_err);
    end
  endtask

  task automatic test_decode();
    run_txn("three_dev",  12'd1164, 10'd192, 1'b1, 6,  4'd3, 8'h07, 1'b0);
    run_txn("zero_dev",   12'd12,   10'd0,   1'b1, 3,  4'd0, 8'h00, 1'b0);
    run_txn("eight_dev",  12'd3084, 10'd512, 1'b0, 11, 4'd8, 8'hFF, 1'b0);
  endtask

  task automatic test_errors();
    run_txn("adc_mismatch", 12'd1164, 10'd128, 1'b1, 6,  4'd3, 8'h00, 1'b1);
    run_txn("remainder",    12'd1165, 10'd192, 1'b1, 6,  4'd3, 8'h00, 1'b1);
    run_txn("underflow",    12'd5,    10'd0,   1'b1, 3,  4'd0, 8'h00, 1'b1);
    run_txn("nine_dev",     12'd3468, 10'd576, 1'b0, 12, 4'd9, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_a", 12'd396, 10'd64,  1'b0, 4, 4'd1, 8'h01, 1'b0);
    run_txn("b2b_b", 12'd780, 10'd128, 1'b0, 5, 4'd2, 8'h03, 1'b0);
  endtask

  task automatic test_reset_mid_div();
    run_txn("pre_reset", 12'd1164, 10'd192, 1'b1, 6, 4'd3, 8'h07, 1'b0);
    @(negedge clk);
    eth_tx_len = 12'd3084;
    adc_rx_len = 10'd512;
    fs = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({fd, dev_num, kdev, err} !== 14'd0) begin
      miss++;
      $display("FAIL reset_mid_div got fd=%b dev=%0d kdev=%h err=%b want all 0", fd, dev_num, kdev, err);
    end
    eth_tx_len = 12'd1164;
    adc_rx_len = 10'd192;
    @(posedge clk);
    #2;
    vecs++;
    if (fd !== 1'b0) begin
      miss++;
      $display("FAIL reset_fd_low got %b want 0", fd);
    end
    rst_n = 1'b1;
    run_txn("post_reset", 12'd1164, 10'd192, 1'b0, 6, 4'd3, 8'h07, 1'b0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_errors();
    test_back_to_back();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
